// File: rtl/axi_rd_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// axi_rd_arbiter_pkg
//   Shared definitions for the AXI4 read-channel arbiter:
//     - arb_state_e : transaction FSM states (IDLE / ADDR / DATA)
//     - AXI constants (INCR burst, OKAY response)
//     - requester index constants (ICache / DCache / uncached load)
//     - idx_width() : width of a requester index for a given count
// -----------------------------------------------------------------------------
package axi_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  localparam int REQ_ICACHE  = 0;
  localparam int REQ_DCACHE  = 1;
  localparam int REQ_UNCACHE = 2;

  // A single requester still needs a 1-bit index so the ports stay legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_arb_picker.sv
// -----------------------------------------------------------------------------
// arb_picker
//   Combinational rotating-priority picker. The search begins at requester
//   'start' and wraps around; the first asserted request wins.
//   With a constant 'start' this is a fixed-priority arbiter whose order is the
//   rotation beginning at that index.
//
// Ports:
//   req   in  N      request vector
//   start in  IDX_W  index searched first
//   gnt   out N      one-hot winner (all zero when no request)
//   idx   out IDX_W  binary index of the winner (0 when no request)
//   any   out 1      at least one request is asserted
// -----------------------------------------------------------------------------
module arb_picker
  import axi_rd_arbiter_pkg::*;
#(
  parameter int N     = 3,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // NOTE: every output gets a default before the search loop, so no path
  // through this block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    int k;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k   = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(start) + i) % N;
      if (!any && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// -----------------------------------------------------------------------------
// axi_rd_arbiter
//   Shares one AXI4 AR/R channel pair among the memory-side read requesters
//   (0: ICache refill, 1: DCache refill, 2: uncached load). One transaction is
//   outstanding at a time: arbitrate (IDLE), present the address (ADDR),
//   steer every beat to the owner (DATA), then release through one IDLE cycle.
//
//   Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration
//   (search starts after the previous winner). Without it, fixed priority
//   DCache > uncache > ICache.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/addr/len/size        per-requester request (flattened vectors)
//   req_gnt                        AR handshake pulse to the owner
//   req_rvalid                     beat valid, owner only
//   req_rlast/rdata/rerr           shared beat sideband
//   arid..arvalid, arready         AXI read-address channel
//   rid..rvalid, rready            AXI read-data channel
// -----------------------------------------------------------------------------
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = 4
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [32*NUM_REQ-1:0]   req_addr,
  input  logic [8*NUM_REQ-1:0]    req_len,
  input  logic [3*NUM_REQ-1:0]    req_size,
  output logic [NUM_REQ-1:0]      req_gnt,
  output logic [NUM_REQ-1:0]      req_rvalid,
  output logic                    req_rlast,
  output logic [31:0]             req_rdata,
  output logic                    req_rerr,

  output logic [ID_W-1:0]         arid,
  output logic [31:0]             araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic                    arvalid,
  input  logic                    arready,

  input  logic [ID_W-1:0]         rid,
  input  logic [31:0]             rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready
);

  localparam int IDX_W = idx_width(NUM_REQ);

  arb_state_e        state, state_nxt;
  logic [IDX_W-1:0]  owner;
  logic              launch;

  logic [NUM_REQ-1:0] win_gnt;
  logic [IDX_W-1:0]   win_idx;
  logic               win_any;
  logic [IDX_W-1:0]   start_ptr;

  // ---------------------------------------------------------------------------
  // Arbitration start point
  // ---------------------------------------------------------------------------
`ifdef ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr;

  // The requester after the last winner is searched first next time.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (launch) begin
      rr_ptr <= IDX_W'((int'(win_idx) + 1) % NUM_REQ);
    end
  end

  assign start_ptr = rr_ptr;
`else
  // Searching from DCache gives the order DCache, uncache, ICache.
  assign start_ptr = IDX_W'(REQ_DCACHE);
`endif

  arb_picker #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req   (req_valid),
    .start (start_ptr),
    .gnt   (win_gnt),
    .idx   (win_idx),
    .any   (win_any)
  );

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Owner and AR payload, captured once at IDLE->ADDR so requester-side
  // changes during the transaction cannot disturb the address channel.
  // ---------------------------------------------------------------------------
  logic [31:0] araddr_q;
  logic [7:0]  arlen_q;
  logic [2:0]  arsize_q;

  // NOTE: these are plain datapath registers, not a memory array, so a
  // reset is cheap; it keeps the AR bus at a known zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner    <= '0;
      araddr_q <= '0;
      arlen_q  <= '0;
      arsize_q <= '0;
    end else if (launch) begin
      owner    <= win_idx;
      araddr_q <= req_addr[int'(win_idx)*32 +: 32];
      arlen_q  <= req_len [int'(win_idx)*8  +: 8];
      arsize_q <= req_size[int'(win_idx)*3  +: 3];
    end
  end

  assign arid    = ID_W'(owner);
  assign araddr  = araddr_q;
  assign arlen   = arlen_q;
  assign arsize  = arsize_q;
  assign arburst = BURST_INCR;

  // ---------------------------------------------------------------------------
  // Next-state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    launch     = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    req_gnt    = '0;
    req_rvalid = '0;

    unique case (state)
      IDLE: begin
        if (win_any) begin
          launch    = 1'b1;
          state_nxt = ADDR;
        end
      end

      ADDR: begin
        arvalid = 1'b1;
        if (arready) begin
          req_gnt[owner] = 1'b1;
          state_nxt      = DATA;
        end
      end

      DATA: begin
        rready = 1'b1;
        if (rvalid) begin
          req_rvalid[owner] = 1'b1;
          if (rlast) begin
            state_nxt = IDLE;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Beat sideband is shared; only the owner's req_rvalid qualifies it.
  assign req_rdata = rdata;
  assign req_rlast = rlast;
  assign req_rerr  = (rresp != RESP_OKAY);

  // ---------------------------------------------------------------------------
  // Protocol checks (ignored by synthesis)
  // ---------------------------------------------------------------------------
  // A mismatched rid is still delivered to the owner; flag it in simulation.
  rid_matches_owner: assert property (@(posedge clk) disable iff (rst)
    (state == DATA && rvalid) |-> (rid == ID_W'(owner)));

  // The interconnect must not return data before the address is accepted.
  no_rvalid_outside_data: assert property (@(posedge clk) disable iff (rst)
    (state != DATA) |-> !rvalid);

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_rd_arbiter
//   Directed bench for axi_rd_arbiter: reset state, single-beat uncached read,
//   simultaneous DCache/ICache requests, AR back-pressure with field changes,
//   gapped beats with an error response, reset mid-burst, and arbitration
//   order with all requesters held high (order depends on ARB_ROUND_ROBIN_EN).
// -----------------------------------------------------------------------------
module tb_axi_rd_arbiter;

  localparam int NUM_REQ = 3;
  localparam int ID_W    = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [32*NUM_REQ-1:0] req_addr;
  logic [8*NUM_REQ-1:0]  req_len;
  logic [3*NUM_REQ-1:0]  req_size;
  logic [NUM_REQ-1:0]    req_gnt;
  logic [NUM_REQ-1:0]    req_rvalid;
  logic                  req_rlast;
  logic [31:0]           req_rdata;
  logic                  req_rerr;
  logic [ID_W-1:0]       arid;
  logic [31:0]           araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;
  logic [ID_W-1:0]       rid;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  axi_rd_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .req_size   (req_size),
    .req_gnt    (req_gnt),
    .req_rvalid (req_rvalid),
    .req_rlast  (req_rlast),
    .req_rdata  (req_rdata),
    .req_rerr   (req_rerr),
    .arid       (arid),
    .araddr     (araddr),
    .arlen      (arlen),
    .arsize     (arsize),
    .arburst    (arburst),
    .arvalid    (arvalid),
    .arready    (arready),
    .rid        (rid),
    .rdata      (rdata),
    .rresp      (rresp),
    .rlast      (rlast),
    .rvalid     (rvalid),
    .rready     (rready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    int beats;
    int exp_id;

    rst       = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_len   = '0;
    req_size  = '0;
    arready   = 1'b0;
    rid       = '0;
    rdata     = '0;
    rresp     = 2'b00;
    rlast     = 1'b0;
    rvalid    = 1'b0;

    // ---------------- Reset state ----------------
    tick();
    tick();
    settle();
    check("rst_arvalid", arvalid, 0);
    check("rst_rready", rready, 0);
    check("rst_gnt", req_gnt, 0);
    check("rst_rvalid", req_rvalid, 0);
    check("rst_araddr", araddr, 0);
    check("rst_arid", arid, 0);
    check("rst_arlen", arlen, 0);
    check("rst_arburst", arburst, 2'b01);
    rst = 1'b0;
    tick();

    // ---------------- Single-beat uncached read ----------------
    req_addr[2*32 +: 32] = 32'h1FAF_0000;
    req_len [2*8  +: 8]  = 8'd0;
    req_size[2*3  +: 3]  = 3'd2;
    req_valid = 3'b100;
    settle();
    check("t1_arvalid_req_cycle", arvalid, 0);
    tick();
    settle();
    check("t1_arvalid", arvalid, 1);
    check("t1_arid", arid, 2);
    check("t1_araddr", araddr, 32'h1FAF_0000);
    check("t1_arlen", arlen, 0);
    check("t1_arsize", arsize, 2);
    check("t1_gnt_before_ready", req_gnt, 0);
    arready = 1'b1;
    settle();
    check("t1_gnt", req_gnt, 3'b100);
    tick();
    req_valid = 3'b000;
    arready   = 1'b0;
    settle();
    check("t1_data_arvalid", arvalid, 0);
    check("t1_data_rready", rready, 1);
    check("t1_data_gnt", req_gnt, 0);
    rvalid = 1'b1; rid = 4'd2; rdata = 32'hDEAD_BEEF; rlast = 1'b1; rresp = 2'b00;
    settle();
    check("t1_rvalid", req_rvalid, 3'b100);
    check("t1_rdata", req_rdata, 32'hDEAD_BEEF);
    check("t1_rlast", req_rlast, 1);
    check("t1_rerr", req_rerr, 0);
    tick();
    rvalid = 1'b0; rlast = 1'b0;
    settle();
    check("t1_idle_rready", rready, 0);
    check("t1_idle_rvalid", req_rvalid, 0);

    // ---------------- DCache vs ICache, 8 beats ----------------
    req_addr[0*32 +: 32] = 32'h1000_0000;
    req_len [0*8  +: 8]  = 8'd7;
    req_size[0*3  +: 3]  = 3'd2;
    req_addr[1*32 +: 32] = 32'h2000_0040;
    req_len [1*8  +: 8]  = 8'd7;
    req_size[1*3  +: 3]  = 3'd2;
    req_valid = 3'b011;
    tick();
    settle();
    check("t2_arid", arid, 1);
    check("t2_araddr", araddr, 32'h2000_0040);
    check("t2_arlen", arlen, 7);
    arready = 1'b1;
    settle();
    check("t2_gnt", req_gnt, 3'b010);
    tick();
    arready   = 1'b0;
    req_valid = 3'b001;
    for (int i = 0; i < 8; i++) begin
      rvalid = 1'b1; rid = 4'd1; rdata = 32'hA000_0000 + i; rlast = (i == 7);
      settle();
      check("t2_rvalid", req_rvalid, 3'b010);
      check("t2_rdata", req_rdata, 32'hA000_0000 + i);
      tick();
    end
    rvalid = 1'b0; rlast = 1'b0;
    settle();
    check("t2_bubble_arvalid", arvalid, 0);
    check("t2_bubble_rready", rready, 0);
    tick();
    settle();
    check("t2_icache_arvalid", arvalid, 1);
    check("t2_icache_arid", arid, 0);
    check("t2_icache_araddr", araddr, 32'h1000_0000);

    // ---------------- AR back-pressure for 5 cycles ----------------
    for (int i = 0; i < 5; i++) begin
      if (i == 2) req_addr[0*32 +: 32] = 32'h5555_0000;
      settle();
      check("t3_stall_arvalid", arvalid, 1);
      check("t3_stall_araddr", araddr, 32'h1000_0000);
      check("t3_stall_gnt", req_gnt, 0);
      tick();
    end
    arready = 1'b1;
    settle();
    check("t3_gnt", req_gnt, 3'b001);
    tick();
    arready   = 1'b0;
    req_valid = 3'b000;

    // ---------------- Gapped beats, error on third ----------------
    beats = 0;
    for (int i = 0; i < 8; i++) begin
      rvalid = 1'b1; rid = 4'd0; rdata = 32'hC000_0000 + i;
      rresp  = (i == 2) ? 2'b10 : 2'b00;
      rlast  = (i == 7);
      settle();
      if (req_rvalid[0]) beats++;
      check("t4_rvalid", req_rvalid, 3'b001);
      check("t4_rerr", req_rerr, (i == 2));
      tick();
      if (i < 7) begin
        rvalid = 1'b0; rresp = 2'b00;
        settle();
        check("t4_gap_rvalid", req_rvalid, 0);
        tick();
      end
    end
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    check("t4_beat_count", beats, 8);

    // ---------------- Reset during DATA beat 3 of 8 ----------------
    req_addr[2*32 +: 32] = 32'h3000_0000;
    req_len [2*8  +: 8]  = 8'd7;
    req_valid = 3'b100;
    tick();
    arready = 1'b1;
    tick();
    arready   = 1'b0;
    req_valid = 3'b000;
    for (int i = 0; i < 2; i++) begin
      rvalid = 1'b1; rid = 4'd2; rdata = 32'hB000_0000 + i; rlast = 1'b0;
      settle();
      check("t5_rvalid", req_rvalid, 3'b100);
      tick();
    end
    rvalid = 1'b1; rdata = 32'hB000_0002; rst = 1'b1;
    settle();
    check("t5_beat3_rvalid", req_rvalid, 3'b100);
    tick();
    rst = 1'b0; rvalid = 1'b0;
    settle();
    check("t5_post_arvalid", arvalid, 0);
    check("t5_post_rready", rready, 0);
    check("t5_post_gnt", req_gnt, 0);
    check("t5_post_rvalid", req_rvalid, 0);
    check("t5_post_araddr", araddr, 0);
    tick();

    // ---------------- All requesters held high ----------------
    req_len   = '0;
    req_valid = 3'b111;
    for (int i = 0; i < 6; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_id = i % 3;
`else
      exp_id = 1;
`endif
      tick();
      settle();
      check("t6_arid", arid, exp_id);
      arready = 1'b1;
      settle();
      check("t6_gnt", req_gnt, 3'b001 << exp_id);
      tick();
      arready = 1'b0;
      rvalid = 1'b1; rid = ID_W'(exp_id); rdata = 32'h6000_0000 + i; rlast = 1'b1;
      settle();
      check("t6_rvalid", req_rvalid, 3'b001 << exp_id);
      tick();
      rvalid = 1'b0; rlast = 1'b0;
    end
    req_valid = 3'b000;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
